// File: rtl/acc_alu_pkg.sv
// Shared op codes, FSM encoding and sizing helpers for the accumulator ALU.
package acc_alu_pkg;

    localparam logic [3:0] OP_ORN       = 4'd0;
    localparam logic [3:0] OP_NAND      = 4'd1;
    localparam logic [3:0] OP_NOTA      = 4'd2;
    localparam logic [3:0] OP_AND       = 4'd3;
    localparam logic [3:0] OP_ADD       = 4'd4;
    localparam logic [3:0] OP_NOR       = 4'd5;
    localparam logic [3:0] OP_POPA      = 4'd6;
    localparam logic [3:0] OP_POPB      = 4'd7;
    localparam logic [3:0] OP_MUL       = 4'd8;
    localparam logic [3:0] OP_NOP_FIRST = 4'd9;
    localparam logic [3:0] OP_NOP_LAST  = 4'd15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Bits needed to count 0..width-1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    // Ops handled bit-serially by the serial unit.
    function automatic logic is_serial_op(input logic [3:0] op);
        return (op == OP_POPA) || (op == OP_POPB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/acc_alu_seq_if.sv
// Handshake/operand bus between the input logic and the accumulator ALU.
interface acc_alu_seq_if #(parameter int WIDTH = 8);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic             clr;
    logic [WIDTH-1:0] acc;
    logic             busy;
    logic             done;
    logic             zero;
    logic             carry;

    modport master (
        output start, op, a, clr,
        input  acc, busy, done, zero, carry
    );

    modport slave (
        input  start, op, a, clr,
        output acc, busy, done, zero, carry
    );
endinterface

// File: rtl/acc_alu_serial_unit.sv
// Bit-serial datapath for POPA/POPB/MUL: one operand bit per RUN edge.
module acc_alu_serial_unit
    import acc_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_run,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_last
);
    localparam int CW = cnt_width(WIDTH);

    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_pop;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH-1:0]   w_pop_inc;
    logic [WIDTH-1:0]   w_pop_nxt;
    logic [2*WIDTH-1:0] w_prod_nxt;

    // Contribution of the current bit; the result includes it so the last
    // edge can write acc directly.  Counts never exceed 2*WIDTH, which fits.
    always_comb begin
        w_pop_inc = '0;
        case (r_op)
            OP_POPA: w_pop_inc = WIDTH'(r_sa[0]);
            OP_POPB: w_pop_inc = WIDTH'(r_sa[0]) + WIDTH'(r_sb[0]);
            default: w_pop_inc = '0;
        endcase
    end

    assign w_pop_nxt  = r_pop + w_pop_inc;
    assign w_prod_nxt = ((r_op == OP_MUL) && r_sa[0]) ? (r_prod + r_mcand) : r_prod;

    assign o_last   = i_run && (r_cnt == CW'(WIDTH - 1));
    assign o_result = (r_op == OP_MUL) ? w_prod_nxt[WIDTH-1:0] : w_pop_nxt;
    assign o_carry  = (r_op == OP_MUL) && (|w_prod_nxt[2*WIDTH-1:WIDTH]);

    // Shadow capture on load, then shift/accumulate one bit per run edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_op    <= '0;
            r_sa    <= '0;
            r_sb    <= '0;
            r_mcand <= '0;
            r_prod  <= '0;
            r_pop   <= '0;
            r_cnt   <= '0;
        end else if (i_clr) begin
            r_cnt   <= '0;
        end else if (i_load) begin
            r_op    <= i_op;
            r_sa    <= i_a;
            r_sb    <= i_b;
            r_mcand <= {{WIDTH{1'b0}}, i_b};
            r_prod  <= '0;
            r_pop   <= '0;
            r_cnt   <= '0;
        end else if (i_run) begin
            r_sa    <= r_sa >> 1;
            r_sb    <= r_sb >> 1;
            r_mcand <= r_mcand << 1;
            r_prod  <= w_prod_nxt;
            r_pop   <= w_pop_nxt;
            r_cnt   <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/acc_alu_seq.sv
// Accumulator ALU: single-cycle logic/add ops plus serial popcount/multiply,
// with start/busy/done handshake, registered flags and synchronous clear.
//   state   | meaning
//   ST_IDLE | accepting start; single-cycle ops complete here
//   ST_RUN  | serial op in progress, start ignored
module acc_alu_seq
    import acc_alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SAT_EN = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    acc_alu_seq_if.slave bus
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic             r_done;
    logic             r_zero;
    logic             r_carry;

    logic             w_accept;
    logic             w_load;
    logic             w_run;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic [WIDTH-1:0] w_ser_res;
    logic             w_ser_carry;
    logic             w_ser_last;

    assign w_accept = (r_state == ST_IDLE) && bus.start && !bus.clr;
    assign w_run    = (r_state == ST_RUN);
    assign w_sum    = {1'b0, bus.a} + {1'b0, r_acc};

    acc_alu_serial_unit #(.WIDTH(WIDTH)) u_serial (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_clr    (bus.clr),
        .i_load   (w_load),
        .i_run    (w_run),
        .i_op     (bus.op),
        .i_a      (bus.a),
        .i_b      (r_acc),
        .o_result (w_ser_res),
        .o_carry  (w_ser_carry),
        .o_last   (w_ser_last)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state; clr forces IDLE and suppresses any load.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        if (bus.clr) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept && is_serial_op(bus.op)) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
                ST_RUN:  if (w_ser_last) w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Single-cycle result; undefined codes behave as NOP.
    always_comb begin
        w_res   = r_acc;
        w_carry = 1'b0;
        case (bus.op)
            OP_ORN:  w_res = ~bus.a | r_acc;
            OP_NAND: w_res = ~bus.a | ~r_acc;
            OP_NOTA: w_res = ~bus.a;
            OP_AND:  w_res = bus.a & r_acc;
            OP_ADD: begin
                w_carry = w_sum[WIDTH];
                w_res   = (SAT_EN && w_sum[WIDTH]) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
            end
            OP_NOR:  w_res = ~bus.a & ~r_acc;
            default: w_res = r_acc;
        endcase
    end

    // Accumulator and flags: clr first, then single-cycle write, then serial finish.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc   <= '0;
            r_done  <= 1'b0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else if (bus.clr) begin
            r_acc   <= '0;
            r_done  <= 1'b0;
            r_zero  <= 1'b1;
            r_carry <= 1'b0;
        end else if (w_accept && !is_serial_op(bus.op)) begin
            r_acc   <= w_res;
            r_done  <= 1'b1;
            r_zero  <= (w_res == '0);
            r_carry <= w_carry;
        end else if (w_ser_last) begin
            r_acc   <= w_ser_res;
            r_done  <= 1'b1;
            r_zero  <= (w_ser_res == '0);
            r_carry <= w_ser_carry;
        end else begin
            r_done  <= 1'b0;
        end
    end

    assign bus.acc   = r_acc;
    assign bus.busy  = w_run;
    assign bus.done  = r_done;
    assign bus.zero  = r_zero;
    assign bus.carry = r_carry;
endmodule

// File: tb/tb_acc_alu_seq.sv
// Bench for acc_alu_seq: arithmetic reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_acc_alu_seq;
    localparam int W  = 8;
    localparam int W1 = W + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    acc_alu_seq_if #(.WIDTH(W)) bus0 ();
    acc_alu_seq_if #(.WIDTH(W)) bus1 ();

    assign bus1.start = bus0.start;
    assign bus1.op    = bus0.op;
    assign bus1.a     = bus0.a;
    assign bus1.clr   = bus0.clr;

    acc_alu_seq #(.WIDTH(W), .SAT_EN(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    acc_alu_seq #(.WIDTH(W), .SAT_EN(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // {carry, result} straight from the operation definitions (wrapping ADD).
    function automatic logic [W:0] ref_eval(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] acc);
        logic [2*W-1:0] p;
        case (op)
            4'd0: return {1'b0, ~a | acc};
            4'd1: return {1'b0, ~a | ~acc};
            4'd2: return {1'b0, ~a};
            4'd3: return {1'b0, a & acc};
            4'd4: return {1'b0, a} + {1'b0, acc};
            4'd5: return {1'b0, ~a & ~acc};
            4'd6: return W1'($countones(a));
            4'd7: return W1'($countones(a) + $countones(acc));
            4'd8: begin
                p = (2*W)'(a) * (2*W)'(acc);
                return {|p[2*W-1:W], p[W-1:0]};
            end
            default: return {1'b0, acc};
        endcase
    endfunction

    function automatic logic ref_is_zero(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] acc);
        logic [W:0] t;
        t = ref_eval(op, a, acc);
        return t[W-1:0] == '0;
    endfunction

    logic [W-1:0] m_acc, m_res;
    logic         m_busy, m_done, m_zero, m_carry, m_rc;
    int           m_left;

    // Reference model: pending serial result released W edges after acceptance.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_acc <= '0; m_res <= '0; m_rc <= 1'b0; m_left <= 0;
            m_busy <= 1'b0; m_done <= 1'b0; m_zero <= 1'b0; m_carry <= 1'b0;
        end else if (bus0.clr) begin
            m_acc <= '0; m_zero <= 1'b1; m_carry <= 1'b0;
            m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_acc <= m_res; m_zero <= (m_res == '0); m_carry <= m_rc;
                m_done <= 1'b1; m_busy <= 1'b0;
            end else begin
                m_done <= 1'b0;
            end
        end else if (bus0.start) begin
            if (bus0.op inside {4'd6, 4'd7, 4'd8}) begin
                {m_rc, m_res} <= ref_eval(bus0.op, bus0.a, m_acc);
                m_left <= W; m_busy <= 1'b1; m_done <= 1'b0;
            end else begin
                {m_carry, m_acc} <= ref_eval(bus0.op, bus0.a, m_acc);
                m_zero <= ref_is_zero(bus0.op, bus0.a, m_acc);
                m_done <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    // Every-cycle compare of the SAT_EN=0 instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc acc",   bus0.acc,   m_acc);
            chk("cyc busy",  bus0.busy,  m_busy);
            chk("cyc done",  bus0.done,  m_done);
            chk("cyc zero",  bus0.zero,  m_zero);
            chk("cyc carry", bus0.carry, m_carry);
        end
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a);
        bus0.start = 1'b1; bus0.op = op; bus0.a = a;
        @(posedge clk); #1;
        bus0.start = 1'b0;
    endtask

    task automatic clr_pulse();
        bus0.clr = 1'b1;
        @(posedge clk); #1;
        bus0.clr = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (!bus0.done && edges < 4*W) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!bus0.done) begin
            n_checks++; n_errors++;
            $display("FAIL wait_done: no done within %0d edges", edges);
        end
    endtask

    int n, dones;

    initial begin
        bus0.start = 1'b0; bus0.op = 4'd0; bus0.a = '0; bus0.clr = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst acc", bus0.acc, 0);   chk("rst busy", bus0.busy, 0);
        chk("rst done", bus0.done, 0); chk("rst zero", bus0.zero, 0);
        chk("rst carry", bus0.carry, 0);
        reset = 1'b0;
        chk_en = 1'b1;

        // ADD twice from reset
        issue(4'd4, 8'h05);
        chk("t1 acc1", bus0.acc, 8'h05); chk("t1 done1", bus0.done, 1);
        chk("t1 carry", bus0.carry, 0);  chk("t1 zero", bus0.zero, 0);
        issue(4'd4, 8'h05);
        chk("t1 acc2", bus0.acc, 8'h0A); chk("t1 done2", bus0.done, 1);

        // ADD overflow: wrap vs saturate
        clr_pulse();
        chk("clr zero", bus0.zero, 1);
        issue(4'd4, 8'hF0);
        issue(4'd4, 8'h20);
        chk("t2 wrap acc", bus0.acc, 8'h10); chk("t2 wrap carry", bus0.carry, 1);
        chk("t2 sat acc", bus1.acc, 8'hFF);  chk("t2 sat carry", bus1.carry, 1);

        // start held: one op per edge, done stays high
        clr_pulse();
        bus0.start = 1'b1; bus0.op = 4'd4; bus0.a = 8'h01;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("b2b done", bus0.done, 1);
        end
        bus0.start = 1'b0;
        chk("b2b acc", bus0.acc, 8'h03);

        // POPB with an ignored start mid-run
        clr_pulse();
        issue(4'd4, 8'h0F);
        issue(4'd7, 8'hFF);
        chk("t3 busy", bus0.busy, 1);
        repeat (3) begin @(posedge clk); #1; end
        bus0.start = 1'b1; bus0.op = 4'd4; bus0.a = 8'h01;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        wait_done(n);
        chk("t3 latency", n, 4);
        chk("t3 acc", bus0.acc, 8'h0C); chk("t3 busy end", bus0.busy, 0);
        @(posedge clk); #1;
        chk("t3 acc hold", bus0.acc, 8'h0C); chk("t3 done drop", bus0.done, 0);

        // MUL
        issue(4'd8, 8'h15);
        wait_done(n);
        chk("t4 latency", n, W);
        chk("t4 acc", bus0.acc, 8'hFC); chk("t4 carry", bus0.carry, 0);
        clr_pulse();
        issue(4'd4, 8'h20);
        issue(4'd8, 8'h10);
        wait_done(n);
        chk("t4 acc2", bus0.acc, 8'h00); chk("t4 carry2", bus0.carry, 1);
        chk("t4 zero2", bus0.zero, 1);

        // async reset mid-MUL, between clock edges
        clr_pulse();
        issue(4'd4, 8'h03);
        issue(4'd8, 8'h05);
        repeat (2) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        chk("t5 rst acc", bus0.acc, 0);   chk("t5 rst busy", bus0.busy, 0);
        chk("t5 rst done", bus0.done, 0); chk("t5 rst zero", bus0.zero, 0);
        chk("t5 rst carry", bus0.carry, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // clr aborts POPA: no done afterwards
        issue(4'd4, 8'h07);
        issue(4'd6, 8'hFF);
        repeat (3) begin @(posedge clk); #1; end
        clr_pulse();
        chk("t5 clr acc", bus0.acc, 0);   chk("t5 clr zero", bus0.zero, 1);
        chk("t5 clr busy", bus0.busy, 0); chk("t5 clr done", bus0.done, 0);
        dones = 0;
        for (int i = 0; i < 2*W; i++) begin
            @(posedge clk); #1;
            if (bus0.done) dones++;
        end
        chk("t5 no done", dones, 0);

        // start dropped when clr is asserted with it
        issue(4'd4, 8'h09);
        bus0.start = 1'b1; bus0.op = 4'd4; bus0.a = 8'h01; bus0.clr = 1'b1;
        @(posedge clk); #1;
        bus0.start = 1'b0; bus0.clr = 1'b0;
        chk("clr+start acc", bus0.acc, 0); chk("clr+start done", bus0.done, 0);

        // logic ops and NOP
        issue(4'd4, 8'h3C);
        issue(4'd3, 8'h0F); chk("t6 and", bus0.acc, 8'h0C);
        issue(4'd5, 8'h0F); chk("t6 nor", bus0.acc, 8'hF0);
        issue(4'd2, 8'hF0); chk("t6 nota", bus0.acc, 8'h0F);
        issue(4'd12, 8'hAA);
        chk("t6 nop acc", bus0.acc, 8'h0F); chk("t6 nop done", bus0.done, 1);
        chk("t6 nop carry", bus0.carry, 0);
        issue(4'd0, 8'hF0); chk("orn", bus0.acc, 8'h0F);
        issue(4'd1, 8'hFF); chk("nand", bus0.acc, 8'hF0);

        repeat (2) @(posedge clk);
        #1 chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
